// File: rtl/rp_decoupler_if.sv
// Handshake bundle on the reconfigurable-partition boundary.
// slave = decoupler side, master = surrounding static/RP environment.
interface rp_decoupler_if #(
    parameter int NUM_ETH = 4
);
    logic [NUM_ETH-1:0] rp_tx_tvalid;
    logic [NUM_ETH-1:0] rp_tx_tlast;
    logic [NUM_ETH-1:0] st_tx_tvalid;
    logic [NUM_ETH-1:0] st_tx_tready;
    logic [NUM_ETH-1:0] rp_tx_tready;

    logic [NUM_ETH-1:0] st_rx_tvalid;
    logic [NUM_ETH-1:0] st_rx_tlast;
    logic [NUM_ETH-1:0] rp_rx_tvalid;

    logic rp_arvalid;
    logic rp_arready;
    logic st_arvalid;
    logic st_arready;

    logic st_rvalid;
    logic st_rlast;
    logic rp_rready;
    logic rp_rvalid;
    logic st_rready;

    logic rp_awvalid;
    logic rp_awready;
    logic st_awvalid;
    logic st_awready;

    logic rp_wvalid;
    logic rp_wready;
    logic st_wvalid;
    logic st_wready;

    logic st_bvalid;
    logic rp_bready;
    logic rp_bvalid;
    logic st_bready;

    modport slave (
        input  rp_tx_tvalid, rp_tx_tlast, st_tx_tready,
        output st_tx_tvalid, rp_tx_tready,
        input  st_rx_tvalid, st_rx_tlast,
        output rp_rx_tvalid,
        input  rp_arvalid, st_arready,
        output rp_arready, st_arvalid,
        input  st_rvalid, st_rlast, rp_rready,
        output rp_rvalid, st_rready,
        input  rp_awvalid, st_awready,
        output rp_awready, st_awvalid,
        input  rp_wvalid, st_wready,
        output rp_wready, st_wvalid,
        input  st_bvalid, rp_bready,
        output rp_bvalid, st_bready
    );

    modport master (
        output rp_tx_tvalid, rp_tx_tlast, st_tx_tready,
        input  st_tx_tvalid, rp_tx_tready,
        output st_rx_tvalid, st_rx_tlast,
        input  rp_rx_tvalid,
        output rp_arvalid, st_arready,
        input  rp_arready, st_arvalid,
        output st_rvalid, st_rlast, rp_rready,
        input  rp_rvalid, st_rready,
        output rp_awvalid, st_awready,
        input  rp_awready, st_awvalid,
        output rp_wvalid, st_wready,
        input  rp_wready, st_wvalid,
        output st_bvalid, rp_bready,
        input  rp_bvalid, st_bready
    );
endinterface

// File: rtl/rp_decoupler.sv
// Drain-then-isolate shutdown controller for a reconfigurable partition.
// Optional drain timeout: define RP_DECOUPLER_TIMEOUT_EN.
module rp_decoupler #(
    parameter int NUM_ETH     = 4,
    parameter int OUTST_W     = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic shutdown_req,
    output logic shutdown_ack,
    output logic active,
    output logic timeout,
    rp_decoupler_if.slave bus
);

`ifdef RP_DECOUPLER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC - 1);
    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DECOUPLED
    } state_t;

    state_t state;
    state_t state_nxt;
    logic force_dec;

    logic [OUTST_W-1:0] ar_cnt;
    logic [OUTST_W-1:0] aw_cnt;
    logic [NUM_ETH-1:0] tx_in_frame;
    logic [NUM_ETH-1:0] rx_in_frame;
    logic [16:0] tmo_cnt;

    logic run;
    logic drain;
    logic coupled;
    logic [NUM_ETH-1:0] tx_pass;
    logic [NUM_ETH-1:0] rx_pass;
    logic [NUM_ETH-1:0] tx_hs;
    logic [NUM_ETH-1:0] rx_hs;
    logic ar_ok;
    logic aw_ok;
    logic ar_inc;
    logic ar_dec;
    logic aw_inc;
    logic aw_dec;
    logic idle;
    logic tmo_hit;

    assign run     = (state == RUN);
    assign drain   = (state == DRAIN);
    assign coupled = run | drain;

    // While draining only frames already under way may finish.
    assign tx_pass = {NUM_ETH{run}} | ({NUM_ETH{drain}} & tx_in_frame);
    assign rx_pass = {NUM_ETH{run}} | ({NUM_ETH{drain}} & rx_in_frame);

    assign bus.st_tx_tvalid = bus.rp_tx_tvalid & tx_pass;
    assign bus.rp_tx_tready = bus.st_tx_tready & tx_pass;
    assign bus.rp_rx_tvalid = bus.st_rx_tvalid & rx_pass;

    assign ar_ok = run & (ar_cnt != CNT_MAX);
    assign aw_ok = run & (aw_cnt != CNT_MAX);

    assign bus.st_arvalid = bus.rp_arvalid & ar_ok;
    assign bus.rp_arready = bus.st_arready & ar_ok;
    assign bus.st_awvalid = bus.rp_awvalid & aw_ok;
    assign bus.rp_awready = bus.st_awready & aw_ok;

    assign bus.rp_rvalid = bus.st_rvalid & coupled;
    assign bus.st_rready = bus.rp_rready & coupled;
    assign bus.st_wvalid = bus.rp_wvalid & coupled;
    assign bus.rp_wready = bus.st_wready & coupled;
    assign bus.rp_bvalid = bus.st_bvalid & coupled;
    assign bus.st_bready = bus.rp_bready & coupled;

    assign tx_hs  = bus.st_tx_tvalid & bus.st_tx_tready;
    assign rx_hs  = bus.rp_rx_tvalid;
    assign ar_inc = bus.st_arvalid & bus.st_arready;
    assign ar_dec = bus.rp_rvalid & bus.rp_rready & bus.st_rlast;
    assign aw_inc = bus.st_awvalid & bus.st_awready;
    assign aw_dec = bus.rp_bvalid & bus.rp_bready;

    assign idle = (ar_cnt == '0) & (aw_cnt == '0) &
                  ~|tx_in_frame & ~|rx_in_frame;

    assign tmo_hit = TMO_EN & drain & (tmo_cnt == TMO_LAST);

    function automatic logic [OUTST_W-1:0] cnt_step(
        input logic [OUTST_W-1:0] cnt,
        input logic inc,
        input logic dec
    );
        logic [OUTST_W-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            res = cnt - 1'b1;
        end
        return res;
    endfunction

    always_comb begin
        state_nxt = state;
        force_dec = 1'b0;
        unique case (state)
            RUN: begin
                if (shutdown_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!shutdown_req) begin
                    state_nxt = RUN;
                end else if (idle) begin
                    state_nxt = DECOUPLED;
                end else if (tmo_hit) begin
                    state_nxt = DECOUPLED;
                    force_dec = 1'b1;
                end
            end
            DECOUPLED: begin
                if (!shutdown_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            active       <= 1'b1;
            shutdown_ack <= 1'b0;
            timeout      <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            active       <= (state_nxt == RUN);
            shutdown_ack <= (state_nxt == DECOUPLED);
            if (force_dec) timeout <= 1'b1;
            if (TMO_EN && drain) tmo_cnt <= tmo_cnt + 17'd1;
            else tmo_cnt <= '0;
        end
    end

    // A forced decouple abandons whatever was still in flight.
    always_ff @(posedge clk) begin
        if (rst || force_dec) begin
            ar_cnt      <= '0;
            aw_cnt      <= '0;
            tx_in_frame <= '0;
            rx_in_frame <= '0;
        end else begin
            ar_cnt      <= cnt_step(ar_cnt, ar_inc, ar_dec);
            aw_cnt      <= cnt_step(aw_cnt, aw_inc, aw_dec);
            tx_in_frame <= (tx_in_frame & ~tx_hs) |
                           (tx_hs & ~bus.rp_tx_tlast);
            rx_in_frame <= (rx_in_frame & ~rx_hs) |
                           (rx_hs & ~bus.st_rx_tlast);
        end
    end

endmodule

// File: tb/tb_rp_decoupler.sv
// Scoreboard bench for rp_decoupler: directed scenarios plus random traffic
// against a cycle-level behavioural model of the shutdown protocol.
module tb_rp_decoupler;

    localparam int N  = 4;
    localparam int OW = 4;
`ifdef RP_DECOUPLER_TIMEOUT_EN
    localparam int TMO    = 100;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 65536;
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int MAXC = (1 << OW) - 1;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_OFF   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic ack;
    logic act;
    logic tmo;

    rp_decoupler_if #(.NUM_ETH(N)) bus ();

    rp_decoupler #(
        .NUM_ETH(N),
        .OUTST_W(OW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .shutdown_req(req),
        .shutdown_ack(ack),
        .active(act),
        .timeout(tmo),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] tx_v;
        logic [N-1:0] tx_l;
        logic [N-1:0] tx_r;
        logic [N-1:0] rx_v;
        logic [N-1:0] rx_l;
        logic arv, arr, rv, rl, rr;
        logic awv, awr, wv, wr, bv, br;
    } stim_t;

    typedef struct packed {
        logic [N-1:0] st_tx_v;
        logic [N-1:0] rp_tx_r;
        logic [N-1:0] rp_rx_v;
        logic st_arv, rp_arr, rp_rv, st_rr, st_awv;
        logic rp_awr, st_wv, rp_wr, rp_bv, st_br;
    } gate_t;

    typedef struct packed {
        gate_t g;
        logic [2:0] st;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int mode = M_RUN;
    int arc = 0;
    int awc = 0;
    bit [N-1:0] txf = '0;
    bit [N-1:0] rxf = '0;
    int age = 0;
    bit tflag = 1'b0;

    task automatic drive(input stim_t s, input bit r, input bit rq);
        gate_t g;
        exp_t e;
        bit run, drn, cpl, ar_ok, aw_ok, idle, hit;
        bit ari, ard, awi, awd;
        bit [N-1:0] txp, rxp, txh, rxh;
        int nm;
        @(posedge clk);
        #1;
        cyc++;
        rst = r;
        req = rq;
        bus.rp_tx_tvalid = s.tx_v;
        bus.rp_tx_tlast  = s.tx_l;
        bus.st_tx_tready = s.tx_r;
        bus.st_rx_tvalid = s.rx_v;
        bus.st_rx_tlast  = s.rx_l;
        bus.rp_arvalid = s.arv;
        bus.st_arready = s.arr;
        bus.st_rvalid  = s.rv;
        bus.st_rlast   = s.rl;
        bus.rp_rready  = s.rr;
        bus.rp_awvalid = s.awv;
        bus.st_awready = s.awr;
        bus.rp_wvalid  = s.wv;
        bus.st_wready  = s.wr;
        bus.st_bvalid  = s.bv;
        bus.rp_bready  = s.br;

        run = (mode == M_RUN);
        drn = (mode == M_DRAIN);
        cpl = run || drn;
        for (int i = 0; i < N; i++) begin
            txp[i] = run || (drn && txf[i]);
            rxp[i] = run || (drn && rxf[i]);
        end
        ar_ok = run && (arc < MAXC);
        aw_ok = run && (awc < MAXC);
        g.st_tx_v = s.tx_v & txp;
        g.rp_tx_r = s.tx_r & txp;
        g.rp_rx_v = s.rx_v & rxp;
        g.st_arv = s.arv && ar_ok;
        g.rp_arr = s.arr && ar_ok;
        g.rp_rv  = s.rv && cpl;
        g.st_rr  = s.rr && cpl;
        g.st_awv = s.awv && aw_ok;
        g.rp_awr = s.awr && aw_ok;
        g.st_wv  = s.wv && cpl;
        g.rp_wr  = s.wr && cpl;
        g.rp_bv  = s.bv && cpl;
        g.st_br  = s.br && cpl;
        e.g  = g;
        e.st = {mode == M_OFF, mode == M_RUN, tflag};
        q.push_back(e);

        if (r) begin
            mode = M_RUN;
            arc = 0;
            awc = 0;
            txf = '0;
            rxf = '0;
            age = 0;
            tflag = 1'b0;
        end else begin
            idle = (arc == 0) && (awc == 0) && (txf == 0) && (rxf == 0);
            hit  = TMO_EN && drn && (age == TMO - 1);
            txh = s.tx_v & s.tx_r & txp;
            rxh = s.rx_v & rxp;
            for (int i = 0; i < N; i++) begin
                if (txh[i]) txf[i] = !s.tx_l[i];
                if (rxh[i]) rxf[i] = !s.rx_l[i];
            end
            ari = g.st_arv && s.arr;
            ard = g.rp_rv && s.rr && s.rl;
            awi = g.st_awv && s.awr;
            awd = g.rp_bv && s.br;
            arc = arc + int'(ari) - int'(ard);
            awc = awc + int'(awi) - int'(awd);
            if (arc < 0) arc = 0;
            if (awc < 0) awc = 0;
            nm = mode;
            case (mode)
                M_RUN: if (rq) nm = M_DRAIN;
                M_DRAIN: begin
                    if (!rq) nm = M_RUN;
                    else if (idle) nm = M_OFF;
                    else if (hit) begin
                        nm = M_OFF;
                        arc = 0;
                        awc = 0;
                        txf = '0;
                        rxf = '0;
                        tflag = 1'b1;
                    end
                end
                default: if (!rq) nm = M_RUN;
            endcase
            age = drn ? age + 1 : 0;
            mode = nm;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        gate_t a;
        if (q.size() != 0) begin
            e = q.pop_front();
            a.st_tx_v = bus.st_tx_tvalid;
            a.rp_tx_r = bus.rp_tx_tready;
            a.rp_rx_v = bus.rp_rx_tvalid;
            a.st_arv = bus.st_arvalid;
            a.rp_arr = bus.rp_arready;
            a.rp_rv  = bus.rp_rvalid;
            a.st_rr  = bus.st_rready;
            a.st_awv = bus.st_awvalid;
            a.rp_awr = bus.rp_awready;
            a.st_wv  = bus.st_wvalid;
            a.rp_wr  = bus.rp_wready;
            a.rp_bv  = bus.rp_bvalid;
            a.st_br  = bus.st_bready;
            tests++;
            if (a !== e.g) begin
                fails++;
                $display("FAIL gates cyc=%0d got=%h exp=%h", cyc, a, e.g);
            end
            tests++;
            if ({ack, act, tmo} !== e.st) begin
                fails++;
                $display("FAIL ack/active/timeout cyc=%0d got=%b exp=%b",
                         cyc, {ack, act, tmo}, e.st);
            end
        end
    end

    initial begin
        stim_t s;
        bit rq;
        s = '0;
        drive(s, 1'b1, 1'b0);
        drive(s, 1'b1, 1'b0);

        // idle shutdown and release
        repeat (3) drive(s, 1'b0, 1'b1);
        repeat (3) drive(s, 1'b0, 1'b0);

        // three reads outstanding, then drain them
        s.arv = 1'b1;
        s.arr = 1'b1;
        repeat (3) drive(s, 1'b0, 1'b0);
        s.arv = 1'b0;
        drive(s, 1'b0, 1'b1);
        s.arv = 1'b1;
        repeat (2) drive(s, 1'b0, 1'b1);
        s = '0;
        s.rv = 1'b1;
        s.rr = 1'b1;
        drive(s, 1'b0, 1'b1);
        s.rl = 1'b1;
        repeat (3) drive(s, 1'b0, 1'b1);
        s = '0;
        repeat (2) drive(s, 1'b0, 1'b1);
        repeat (2) drive(s, 1'b0, 1'b0);

        // TX ch2 mid-frame at shutdown, ch0 must stay blocked
        s.tx_r = '1;
        s.tx_v = 4'b0100;
        repeat (5) drive(s, 1'b0, 1'b0);
        drive(s, 1'b0, 1'b1);
        s.tx_v = 4'b0101;
        repeat (3) drive(s, 1'b0, 1'b1);
        s.tx_l = 4'b0101;
        drive(s, 1'b0, 1'b1);
        s.tx_l = '0;
        repeat (3) drive(s, 1'b0, 1'b1);
        s = '0;
        repeat (2) drive(s, 1'b0, 1'b0);

        // AW and B in the same cycle
        s.awv = 1'b1;
        s.awr = 1'b1;
        drive(s, 1'b0, 1'b0);
        s.bv = 1'b1;
        s.br = 1'b1;
        drive(s, 1'b0, 1'b0);
        s.awv = 1'b0;
        drive(s, 1'b0, 1'b0);
        drive(s, 1'b0, 1'b0);

        // AR counter saturation
        s = '0;
        s.arv = 1'b1;
        s.arr = 1'b1;
        repeat (MAXC + 3) drive(s, 1'b0, 1'b0);
        s.rv = 1'b1;
        s.rr = 1'b1;
        s.rl = 1'b1;
        s.arv = 1'b0;
        drive(s, 1'b0, 1'b0);
        s.rv = 1'b0;
        s.arv = 1'b1;
        repeat (2) drive(s, 1'b0, 1'b0);

        // reset in the middle of a drain
        s = '0;
        repeat (2) drive(s, 1'b0, 1'b1);
        drive(s, 1'b1, 1'b1);
        repeat (2) drive(s, 1'b0, 1'b0);

`ifdef RP_DECOUPLER_TIMEOUT_EN
        s.arv = 1'b1;
        s.arr = 1'b1;
        drive(s, 1'b0, 1'b0);
        s = '0;
        repeat (TMO + 5) drive(s, 1'b0, 1'b1);
        repeat (3) drive(s, 1'b0, 1'b0);
        drive(s, 1'b1, 1'b0);
`endif

        rq = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(29) == 0) rq = !rq;
            s.tx_v = N'($urandom);
            s.tx_l = N'($urandom & $urandom);
            s.tx_r = N'($urandom | $urandom);
            s.rx_v = N'($urandom);
            s.rx_l = N'($urandom & $urandom);
            s.arv = 1'($urandom);
            s.arr = 1'($urandom);
            s.rv  = ($urandom_range(3) == 0);
            s.rl  = 1'($urandom);
            s.rr  = 1'($urandom);
            s.awv = 1'($urandom);
            s.awr = 1'($urandom);
            s.wv  = 1'($urandom);
            s.wr  = 1'($urandom);
            s.bv  = ($urandom_range(3) == 0);
            s.br  = 1'($urandom);
            drive(s, ($urandom_range(499) == 0), rq);
        end

        repeat (2) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
